m_ifetch_queue: RTL and testbench

Instruction fetch front-end for the RISC-V core: owns the fetch PC, issues word requests to the instruction memory, and buffers returned instructions with their PCs in a small queue. It sits directly upstream of decode and hands decode one `{pc, instruction}` pair per valid/ready transfer. A redirect from the branch/jump resolution logic flushes the queue and restarts fetch at the target.

---
 rtl/m_ifq_pkg.sv | 15 +
 rtl/m_ifetch_queue_if.sv | 28 ++
 rtl/m_ifq_fifo.sv | 53 +++++
 rtl/m_ifetch_queue.sv | 79 +++++++
 tb/tb_m_ifetch_queue.sv | 357 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/m_ifq_pkg.sv
// Shared types and constants for the instruction fetch queue.
// An entry holds the fetch PC in the upper word and the instruction in the lower word.
package m_ifq_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } t_ifq_state;

    localparam int ILEN      = 32;
    localparam int IFQ_DEPTH = 4;
    localparam int ENTRY_W   = 2 * ILEN;

endpackage

// File: rtl/m_ifetch_queue_if.sv
// Fetch front-end bus: instruction memory request/response plus the decode handoff.
// The master side is the fetch queue; the slave side is memory, decode and branch resolution.
interface m_ifetch_queue_if #(parameter int DEPTH = m_ifq_pkg::IFQ_DEPTH);
    import m_ifq_pkg::*;

    logic                      w_redir;
    logic [ILEN-1:0]           w_redir_pc;
    logic                      w_imem_req;
    logic [ILEN-1:0]           w_imem_adr;
    logic                      w_imem_rvalid;
    logic [ILEN-1:0]           w_imem_rdata;
    logic                      w_ir_valid;
    logic [ILEN-1:0]           w_ir;
    logic [ILEN-1:0]           w_ir_pc;
    logic                      w_ir_ready;
    logic [$clog2(DEPTH):0]    w_count;

    modport master (
        input  w_redir, w_redir_pc, w_imem_rvalid, w_imem_rdata, w_ir_ready,
        output w_imem_req, w_imem_adr, w_ir_valid, w_ir, w_ir_pc, w_count
    );

    modport slave (
        output w_redir, w_redir_pc, w_imem_rvalid, w_imem_rdata, w_ir_ready,
        input  w_imem_req, w_imem_adr, w_ir_valid, w_ir, w_ir_pc, w_count
    );

endinterface

// File: rtl/m_ifq_fifo.sv
// Circular buffer of {pc, instruction} entries with flush; the head reads zero when empty.
module m_ifq_fifo
    import m_ifq_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH
)
(
    input  logic                     w_clk,
    input  logic                     w_rst,
    input  logic                     w_push,
    input  logic                     w_pop,
    input  logic                     w_flush,
    input  logic [ENTRY_W-1:0]       w_din,
    output logic [ENTRY_W-1:0]       w_dout,
    output logic [$clog2(DEPTH):0]   w_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]      r_head;
    logic [AW-1:0]      r_tail;
    logic [CW-1:0]      r_count;

    // Flush wins over push and pop; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_tail <= r_tail + AW'(1);
            if (w_pop)
                r_head <= r_head + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge w_clk) begin
        if (w_push && !w_flush)
            r_mem[r_tail] <= w_din;
    end

    assign w_dout  = (r_count != '0) ? r_mem[r_head] : '0;
    assign w_count = r_count;

endmodule

// File: rtl/m_ifetch_queue.sv
// Instruction fetch front-end: owns the fetch PC, keeps at most one memory request in flight,
// and queues returned instructions with their PCs for decode.
module m_ifetch_queue
    import m_ifq_pkg::*;
#(
    parameter int              DEPTH    = IFQ_DEPTH,
    parameter logic [ILEN-1:0] RESET_PC = 32'h0
)
(
    input  logic              w_clk,
    input  logic              w_rst,
    m_ifetch_queue_if.master  bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    t_ifq_state         r_state;
    logic [ILEN-1:0]    r_fpc;
    logic [ILEN-1:0]    r_req_pc;

    logic               w_push;
    logic               w_pop;
    logic               w_resp;
    logic               w_issue_state;
    logic               w_slot_ok;
    logic               w_issue;
    logic [CW:0]        w_occ_next;
    logic [CW-1:0]      w_count_q;
    logic [ENTRY_W-1:0] w_head;

    assign w_resp        = bus.w_imem_rvalid && (r_state == S_WAIT || r_state == S_DROP);
    assign w_push        = bus.w_imem_rvalid && (r_state == S_WAIT) && !bus.w_redir;
    assign w_pop         = bus.w_ir_valid && bus.w_ir_ready;
    assign w_issue_state = (r_state == S_IDLE) || w_resp;

    // Occupancy after this edge must leave room for the new request's reserved slot.
    assign w_occ_next = {1'b0, w_count_q} + (CW+1)'(w_push) - (CW+1)'(w_pop);
    assign w_slot_ok  = w_occ_next < (CW+1)'(DEPTH);
    assign w_issue    = !w_rst && !bus.w_redir && w_issue_state && w_slot_ok;

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            r_state  <= S_IDLE;
            r_fpc    <= RESET_PC;
            r_req_pc <= '0;
        end else if (bus.w_redir) begin
            r_fpc <= bus.w_redir_pc & ~32'h3;
            if (r_state != S_IDLE && !bus.w_imem_rvalid)
                r_state <= S_DROP;
            else
                r_state <= S_IDLE;
        end else if (w_issue) begin
            r_fpc    <= r_fpc + 32'd4;
            r_req_pc <= r_fpc;
            r_state  <= S_WAIT;
        end else if (w_resp) begin
            r_state <= S_IDLE;
        end
    end

    m_ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .w_clk   (w_clk),
        .w_rst   (w_rst),
        .w_push  (w_push),
        .w_pop   (w_pop),
        .w_flush (bus.w_redir),
        .w_din   ({r_req_pc, bus.w_imem_rdata}),
        .w_dout  (w_head),
        .w_count (w_count_q)
    );

    assign bus.w_imem_req = w_issue;
    assign bus.w_imem_adr = r_fpc;
    assign bus.w_ir_valid = (w_count_q != '0);
    assign bus.w_ir_pc    = w_head[ENTRY_W-1:ILEN];
    assign bus.w_ir       = w_head[ILEN-1:0];
    assign bus.w_count    = w_count_q;

endmodule

// File: tb/tb_m_ifetch_queue.sv
// Directed bench for m_ifetch_queue with a behavioural instruction memory (data = adr ^ 0xFFFF0000).
module tb_m_ifetch_queue;
    import m_ifq_pkg::*;

    localparam int DEPTH = 4;

    logic w_clk = 1'b0;
    logic w_rst = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    int          mem_lat    = 1;
    logic        inj_rvalid = 1'b0;
    logic [31:0] req_q[$];
    int          cyc        = 0;
    logic        pend       = 1'b0;
    int          due        = 0;
    logic [31:0] pend_adr   = '0;

    m_ifetch_queue_if #(.DEPTH(DEPTH)) bus();

    m_ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .w_clk (w_clk),
        .w_rst (w_rst),
        .bus   (bus.master)
    );

    always #5 w_clk = ~w_clk;

    // Memory: response driven at the falling edge, then the request of this cycle sampled 1 ns later.
    initial begin
        bus.w_imem_rvalid = 1'b0;
        bus.w_imem_rdata  = '0;
        forever begin
            @(negedge w_clk);
            cyc++;
            if (pend && cyc >= due) begin
                bus.w_imem_rvalid = 1'b1;
                bus.w_imem_rdata  = pend_adr ^ 32'hFFFF0000;
                pend = 1'b0;
            end else begin
                bus.w_imem_rvalid = inj_rvalid;
                bus.w_imem_rdata  = inj_rvalid ? 32'hDEADBEEF : 32'h0;
            end
            #1;
            if (bus.w_imem_req === 1'b1) begin
                pend     = 1'b1;
                pend_adr = bus.w_imem_adr;
                due      = cyc + mem_lat;
                req_q.push_back(bus.w_imem_adr);
            end
        end
    end

    task automatic step();
        @(posedge w_clk);
        #1;
    endtask

    task automatic mid();
        @(negedge w_clk);
        #2;
    endtask

    task automatic do_reset();
        w_rst = 1'b1;
        bus.w_redir = 1'b0;
        bus.w_ir_ready = 1'b0;
        inj_rvalid = 1'b0;
        repeat (5) step();
        req_q.delete();
    endtask

    task automatic test_reset();
        logic [68:0] got;
        #1 w_rst = 1'b1;
        #1;
        got = {bus.w_ir_valid, bus.w_count, bus.w_ir_pc, bus.w_ir, bus.w_imem_req};
        n_checks++;
        if (got !== 69'h0) begin
            n_errors++;
            $display("[TB] FAIL reset_async got %h exp 0", got);
        end
        repeat (2) step();
        got = {bus.w_ir_valid, bus.w_count, bus.w_ir_pc, bus.w_ir, bus.w_imem_req};
        n_checks++;
        if (got !== 69'h0) begin
            n_errors++;
            $display("[TB] FAIL reset_held got %h exp 0", got);
        end
    endtask

    task automatic test_streaming();
        logic [67:0] got;
        logic [67:0] exp;
        do_reset();
        mem_lat = 1;
        bus.w_ir_ready = 1'b1;
        w_rst = 1'b0;
        step();
        step();
        for (int i = 0; i < 6; i++) begin
            got = {bus.w_ir_valid, bus.w_count, bus.w_ir_pc, bus.w_ir};
            exp = {1'b1, 3'd1, 32'(4*i), 32'(4*i) ^ 32'hFFFF0000};
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("[TB] FAIL stream_head[%0d] got %h exp %h", i, got, exp);
            end
            mid();
            n_checks++;
            if ({bus.w_imem_req, bus.w_imem_adr} !== {1'b1, 32'(4*i+8)}) begin
                n_errors++;
                $display("[TB] FAIL stream_req[%0d] got %b/%h exp 1/%h", i, bus.w_imem_req, bus.w_imem_adr, 4*i+8);
            end
            step();
        end
        n_checks++;
        if (req_q.size() != 8 || req_q[7] !== 32'h1C) begin
            n_errors++;
            $display("[TB] FAIL stream_req_count got %0d exp 8", req_q.size());
        end
    endtask

    task automatic test_backpressure();
        logic [67:0] got;
        do_reset();
        mem_lat = 1;
        bus.w_ir_ready = 1'b0;
        w_rst = 1'b0;
        repeat (6) step();
        got = {bus.w_ir_valid, bus.w_count, bus.w_ir_pc, bus.w_ir};
        n_checks++;
        if (got !== {1'b1, 3'd4, 32'h0, 32'hFFFF0000}) begin
            n_errors++;
            $display("[TB] FAIL bp_full got %h exp %h", got, {1'b1, 3'd4, 32'h0, 32'hFFFF0000});
        end
        mid();
        n_checks++;
        if (bus.w_imem_req !== 1'b0 || req_q.size() != 4 || req_q[3] !== 32'hC) begin
            n_errors++;
            $display("[TB] FAIL bp_stall got req %b nreq %0d exp req 0 nreq 4", bus.w_imem_req, req_q.size());
        end
        step();
        bus.w_ir_ready = 1'b1;
        mid();
        n_checks++;
        if ({bus.w_imem_req, bus.w_imem_adr} !== {1'b1, 32'h10}) begin
            n_errors++;
            $display("[TB] FAIL bp_pop_issue got %b/%h exp 1/00000010", bus.w_imem_req, bus.w_imem_adr);
        end
        step();
        bus.w_ir_ready = 1'b0;
        got = {bus.w_ir_valid, bus.w_count, bus.w_ir_pc, bus.w_ir};
        n_checks++;
        if (got !== {1'b1, 3'd3, 32'h4, 32'hFFFF0004}) begin
            n_errors++;
            $display("[TB] FAIL bp_after_pop got %h exp %h", got, {1'b1, 3'd3, 32'h4, 32'hFFFF0004});
        end
        step();
        n_checks++;
        if (bus.w_count !== 3'd4) begin
            n_errors++;
            $display("[TB] FAIL bp_refill got %0d exp 4", bus.w_count);
        end
        inj_rvalid = 1'b1;
        step();
        inj_rvalid = 1'b0;
        got = {bus.w_ir_valid, bus.w_count, bus.w_ir_pc, bus.w_ir};
        n_checks++;
        if (got !== {1'b1, 3'd4, 32'h4, 32'hFFFF0004}) begin
            n_errors++;
            $display("[TB] FAIL idle_rvalid_ignored got %h exp %h", got, {1'b1, 3'd4, 32'h4, 32'hFFFF0004});
        end
    endtask

    task automatic test_redirect_outstanding();
        int n;
        do_reset();
        mem_lat = 3;
        bus.w_ir_ready = 1'b1;
        w_rst = 1'b0;
        step();
        bus.w_redir = 1'b1;
        bus.w_redir_pc = 32'h100;
        mid();
        n_checks++;
        if (bus.w_imem_req !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL redir_no_issue got %b exp 0", bus.w_imem_req);
        end
        step();
        bus.w_redir = 1'b0;
        mid();
        n_checks++;
        if (bus.w_imem_req !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL drop_wait got %b exp 0", bus.w_imem_req);
        end
        step();
        mid();
        n_checks++;
        if ({bus.w_imem_req, bus.w_imem_adr} !== {1'b1, 32'h100}) begin
            n_errors++;
            $display("[TB] FAIL drop_issue got %b/%h exp 1/00000100", bus.w_imem_req, bus.w_imem_adr);
        end
        step();
        n_checks++;
        if ({bus.w_ir_valid, bus.w_count} !== 4'h0) begin
            n_errors++;
            $display("[TB] FAIL stale_not_pushed got %b/%0d exp 0/0", bus.w_ir_valid, bus.w_count);
        end
        n = 0;
        while (bus.w_ir_valid !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        n_checks++;
        if ({bus.w_ir_valid, bus.w_ir_pc, bus.w_ir} !== {1'b1, 32'h100, 32'hFFFF0100}) begin
            n_errors++;
            $display("[TB] FAIL redir_first_head got %b/%h/%h exp 1/00000100/ffff0100", bus.w_ir_valid, bus.w_ir_pc, bus.w_ir);
        end
    endtask

    task automatic test_redirect_rvalid();
        logic [67:0] got;
        do_reset();
        mem_lat = 1;
        bus.w_ir_ready = 1'b0;
        w_rst = 1'b0;
        repeat (3) step();
        n_checks++;
        if (bus.w_count !== 3'd2) begin
            n_errors++;
            $display("[TB] FAIL pre_redir_count got %0d exp 2", bus.w_count);
        end
        bus.w_redir = 1'b1;
        bus.w_redir_pc = 32'h200;
        step();
        bus.w_redir = 1'b0;
        got = {bus.w_ir_valid, bus.w_count, bus.w_ir_pc, bus.w_ir};
        n_checks++;
        if (got !== 68'h0) begin
            n_errors++;
            $display("[TB] FAIL flush_empty got %h exp 0", got);
        end
        mid();
        n_checks++;
        if ({bus.w_imem_req, bus.w_imem_adr} !== {1'b1, 32'h200}) begin
            n_errors++;
            $display("[TB] FAIL redir_rvalid_issue got %b/%h exp 1/00000200", bus.w_imem_req, bus.w_imem_adr);
        end
        step();
        step();
        got = {bus.w_ir_valid, bus.w_count, bus.w_ir_pc, bus.w_ir};
        n_checks++;
        if (got !== {1'b1, 3'd1, 32'h200, 32'hFFFF0200}) begin
            n_errors++;
            $display("[TB] FAIL redir_rvalid_head got %h exp %h", got, {1'b1, 3'd1, 32'h200, 32'hFFFF0200});
        end
    endtask

    task automatic test_unaligned_redirect();
        logic [67:0] got;
        do_reset();
        mem_lat = 1;
        bus.w_ir_ready = 1'b0;
        bus.w_redir = 1'b1;
        bus.w_redir_pc = 32'h103;
        w_rst = 1'b0;
        mid();
        n_checks++;
        if (bus.w_imem_req !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL idle_redir_no_issue got %b exp 0", bus.w_imem_req);
        end
        step();
        bus.w_redir = 1'b0;
        mid();
        n_checks++;
        if ({bus.w_imem_req, bus.w_imem_adr} !== {1'b1, 32'h100}) begin
            n_errors++;
            $display("[TB] FAIL unaligned_adr got %b/%h exp 1/00000100", bus.w_imem_req, bus.w_imem_adr);
        end
        step();
        step();
        got = {bus.w_ir_valid, bus.w_count, bus.w_ir_pc, bus.w_ir};
        n_checks++;
        if (got !== {1'b1, 3'd1, 32'h100, 32'hFFFF0100}) begin
            n_errors++;
            $display("[TB] FAIL unaligned_head got %h exp %h", got, {1'b1, 3'd1, 32'h100, 32'hFFFF0100});
        end
    endtask

    task automatic test_async_reset();
        logic [68:0] got;
        int n;
        do_reset();
        mem_lat = 3;
        bus.w_ir_ready = 1'b0;
        w_rst = 1'b0;
        n = 0;
        while (bus.w_count !== 3'd3 && n < 30) begin
            step();
            n++;
        end
        n_checks++;
        if (bus.w_count !== 3'd3) begin
            n_errors++;
            $display("[TB] FAIL fill_to_3 got %0d exp 3", bus.w_count);
        end
        #3 w_rst = 1'b1;
        #1;
        got = {bus.w_ir_valid, bus.w_count, bus.w_ir_pc, bus.w_ir, bus.w_imem_req};
        n_checks++;
        if (got !== 69'h0) begin
            n_errors++;
            $display("[TB] FAIL async_reset_outputs got %h exp 0", got);
        end
        repeat (5) step();
        req_q.delete();
        w_rst = 1'b0;
        mid();
        n_checks++;
        if ({bus.w_imem_req, bus.w_imem_adr, bus.w_count} !== {1'b1, 32'h0, 3'd0}) begin
            n_errors++;
            $display("[TB] FAIL restart_req got %b/%h/%0d exp 1/00000000/0", bus.w_imem_req, bus.w_imem_adr, bus.w_count);
        end
        n = 0;
        while (bus.w_ir_valid !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        n_checks++;
        if ({bus.w_ir_valid, bus.w_count, bus.w_ir_pc, bus.w_ir} !== {1'b1, 3'd1, 32'h0, 32'hFFFF0000}) begin
            n_errors++;
            $display("[TB] FAIL restart_head got %b/%0d/%h/%h exp 1/1/00000000/ffff0000", bus.w_ir_valid, bus.w_count, bus.w_ir_pc, bus.w_ir);
        end
    endtask

    initial begin
        bus.w_redir    = 1'b0;
        bus.w_redir_pc = '0;
        bus.w_ir_ready = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_redirect_outstanding();
        test_redirect_rvalid();
        test_unaligned_redirect();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
